// File: rtl/conv3x3_mac_relu_if.sv
// Signal bundle between the 3x3 window generator / config master and the
// conv3x3_mac_relu engine. The master drives the window, strobe and config
// write; the engine (slave) returns the result pixel and frame marker.
interface conv3x3_mac_relu_if #(
  parameter int DATA_WIDHT = 8,
  parameter int BIAS_WIDTH = 16
);
  logic [DATA_WIDHT-1:0] Data_In1;
  logic [DATA_WIDHT-1:0] Data_In2;
  logic [DATA_WIDHT-1:0] Data_In3;
  logic [DATA_WIDHT-1:0] Data_In4;
  logic [DATA_WIDHT-1:0] Data_In5;
  logic [DATA_WIDHT-1:0] Data_In6;
  logic [DATA_WIDHT-1:0] Data_In7;
  logic [DATA_WIDHT-1:0] Data_In8;
  logic [DATA_WIDHT-1:0] Data_In9;
  logic                  Valid_In;
  logic                  Cfg_Wr;
  logic [3:0]            Cfg_Addr;
  logic [BIAS_WIDTH-1:0] Cfg_Data;
  logic [DATA_WIDHT-1:0] Data_Out;
  logic                  Valid_Out;
  logic                  Frame_Done;

  modport master (
    output Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
           Data_In6, Data_In7, Data_In8, Data_In9,
           Valid_In, Cfg_Wr, Cfg_Addr, Cfg_Data,
    input  Data_Out, Valid_Out, Frame_Done
  );

  modport slave (
    input  Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
           Data_In6, Data_In7, Data_In8, Data_In9,
           Valid_In, Cfg_Wr, Cfg_Addr, Cfg_Data,
    output Data_Out, Valid_Out, Frame_Done
  );
endinterface

// File: rtl/conv3x3_mac_relu.sv
// Pipelined 3x3 convolution: nine signed weights, signed bias, arithmetic
// shift, ReLU and saturation to an unsigned pixel. Windows that straddle two
// image rows are dropped, so one frame yields (W-2)*(H-2) results and a
// Frame_Done pulse on the last one. Four register stages, no back-pressure.
module conv3x3_mac_relu #(
  parameter int DATA_WIDHT   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 16,
  parameter int IMG_WIDHT    = 220,
  parameter int IMG_HEIGHT   = 220,
  parameter int SHIFT        = 0,
  parameter int ACC_WIDTH    = 24
) (
  input logic             clk,
  input logic             rst,
  conv3x3_mac_relu_if.slave bus
);

  localparam int PROD_WIDTH = DATA_WIDHT + WEIGHT_WIDTH + 1;
  localparam int COL_WIDTH  = $clog2(IMG_WIDHT);
  localparam int LAST_BEAT  = (IMG_HEIGHT - 2) * IMG_WIDHT - 2;
  localparam int BEAT_WIDTH = $clog2(LAST_BEAT + 1);
  localparam int OUT_TOTAL  = (IMG_WIDHT - 2) * (IMG_HEIGHT - 2);
  localparam int OUT_WIDTH  = $clog2(OUT_TOTAL + 1);

  // Zero-extend the pixel, sign-extend the weight, multiply at product width.
  function automatic logic signed [PROD_WIDTH-1:0] mul(
    input logic        [DATA_WIDHT-1:0]   p,
    input logic signed [WEIGHT_WIDTH-1:0] w
  );
    logic signed [PROD_WIDTH-1:0] pe;
    logic signed [PROD_WIDTH-1:0] we;
    pe = $signed({{(PROD_WIDTH-DATA_WIDHT){1'b0}}, p});
    we = {{(PROD_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
    return pe * we;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] ext_prod(
    input logic signed [PROD_WIDTH-1:0] v
  );
    return {{(ACC_WIDTH-PROD_WIDTH){v[PROD_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] ext_bias(
    input logic signed [BIAS_WIDTH-1:0] v
  );
    return {{(ACC_WIDTH-BIAS_WIDTH){v[BIAS_WIDTH-1]}}, v};
  endfunction

  logic [DATA_WIDHT-1:0] pix [9];
  assign pix[0] = bus.Data_In1;
  assign pix[1] = bus.Data_In2;
  assign pix[2] = bus.Data_In3;
  assign pix[3] = bus.Data_In4;
  assign pix[4] = bus.Data_In5;
  assign pix[5] = bus.Data_In6;
  assign pix[6] = bus.Data_In7;
  assign pix[7] = bus.Data_In8;
  assign pix[8] = bus.Data_In9;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic signed [WEIGHT_WIDTH-1:0] weight [9];
  logic signed [BIAS_WIDTH-1:0]   bias;

  // Weight/bias write port; a window sampled on the same edge still sees the old values.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: this small register file is reset because a cleared kernel is part of the
  // block's defined power-up behaviour; a large RAM would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) weight[i] <= '0;
      bias <= '0;
    end else if (bus.Cfg_Wr) begin
      for (int i = 0; i < 9; i++) begin
        if (bus.Cfg_Addr == 4'(i)) weight[i] <= bus.Cfg_Data[WEIGHT_WIDTH-1:0];
      end
      if (bus.Cfg_Addr == 4'd9) bias <= bus.Cfg_Data;
    end
  end

  // ---------------------------------------------------------------------------
  // Row-straddle masking and frame tracking
  // ---------------------------------------------------------------------------
  logic [COL_WIDTH-1:0]  col;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic                  last_beat;
  logic                  in_row;

  assign last_beat = bus.Valid_In && (beat_cnt == BEAT_WIDTH'(LAST_BEAT - 1));
  assign in_row    = (col >= COL_WIDTH'(2));

  // Column position of the newest pixel; realigned to 2 after the frame's last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= COL_WIDTH'(2);
      beat_cnt <= '0;
    end else if (bus.Valid_In) begin
      if (last_beat) begin
        col      <= COL_WIDTH'(2);
        beat_cnt <= '0;
      end else begin
        col      <= (col == COL_WIDTH'(IMG_WIDHT - 1)) ? '0 : col + COL_WIDTH'(1);
        beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic pipeline
  // ---------------------------------------------------------------------------
  logic                         s1_valid, s2_valid, s3_valid;
  logic signed [PROD_WIDTH-1:0] s1_prod [9];
  logic signed [BIAS_WIDTH-1:0] s1_bias, s2_bias;
  logic signed [ACC_WIDTH-1:0]  s2_part [3];
  logic signed [ACC_WIDTH-1:0]  s3_sum;

  // Valid bits, one per stage; straddling windows enter with valid cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= bus.Valid_In && in_row;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Datapath S1..S3: products, partial sums of three, final sum plus bias.
  // The bias travels with its window so a later write cannot leak into it.
  // NOTE: datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) s1_prod[i] <= mul(pix[i], weight[i]);
    s1_bias <= bias;
    for (int k = 0; k < 3; k++) begin
      s2_part[k] <= ext_prod(s1_prod[3*k]) + ext_prod(s1_prod[3*k+1])
                  + ext_prod(s1_prod[3*k+2]);
    end
    s2_bias <= s1_bias;
    s3_sum  <= s2_part[0] + s2_part[1] + s2_part[2] + ext_bias(s2_bias);
  end

  // Shift, ReLU and saturation of the S3 sum.
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DATA_WIDHT-1:0]       clipped;

  // Clamp to [0, 2^DATA_WIDHT-1].
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    shifted = s3_sum >>> SHIFT;
    clipped = shifted[DATA_WIDHT-1:0];
    if (shifted[ACC_WIDTH-1]) begin
      clipped = '0;
    end else if (|shifted[ACC_WIDTH-2:DATA_WIDHT]) begin
      clipped = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage and result counter
  // ---------------------------------------------------------------------------
  logic [DATA_WIDHT-1:0] data_out;
  logic                  valid_out;
  logic                  frame_done;
  logic [OUT_WIDTH-1:0]  out_cnt;
  logic                  last_result;

  assign last_result = (out_cnt == OUT_WIDTH'(OUT_TOTAL - 1));

  // S4: register the clamped pixel; Data_Out holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      out_cnt    <= '0;
    end else begin
      valid_out  <= s3_valid;
      frame_done <= s3_valid && last_result;
      if (s3_valid) begin
        data_out <= clipped;
        out_cnt  <= last_result ? '0 : out_cnt + OUT_WIDTH'(1);
      end
    end
  end

  assign bus.Data_Out   = data_out;
  assign bus.Valid_Out  = valid_out;
  assign bus.Frame_Done = frame_done;

endmodule

// File: tb/tb_conv3x3_mac_relu.sv
// Self-checking bench for conv3x3_mac_relu on a 5x5 image. Two instances
// share every input: one with SHIFT=0, one with SHIFT=2. A cycle-stamped
// expected-result queue, built from the arithmetic rules and the frame
// geometry, is compared against both instances every clock.
module tb_conv3x3_mac_relu;

  localparam int DW      = 8;
  localparam int WW      = 8;
  localparam int BW      = 16;
  localparam int IW      = 5;
  localparam int IH      = 5;
  localparam int AW      = 24;
  localparam int N_RES   = (IW - 2) * (IH - 2);
  localparam int N_BEATS = (IH - 2) * IW - 2;
  localparam int PMAX    = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic [DW-1:0] pix_drv [9];
  logic          valid_drv = 1'b0;
  logic          cfg_wr_drv = 1'b0;
  logic [3:0]    cfg_addr_drv = '0;
  logic [BW-1:0] cfg_data_drv = '0;

  conv3x3_mac_relu_if #(.DATA_WIDHT(DW), .BIAS_WIDTH(BW)) bus0 ();
  conv3x3_mac_relu_if #(.DATA_WIDHT(DW), .BIAS_WIDTH(BW)) bus1 ();

  assign bus0.Data_In1 = pix_drv[0];  assign bus1.Data_In1 = pix_drv[0];
  assign bus0.Data_In2 = pix_drv[1];  assign bus1.Data_In2 = pix_drv[1];
  assign bus0.Data_In3 = pix_drv[2];  assign bus1.Data_In3 = pix_drv[2];
  assign bus0.Data_In4 = pix_drv[3];  assign bus1.Data_In4 = pix_drv[3];
  assign bus0.Data_In5 = pix_drv[4];  assign bus1.Data_In5 = pix_drv[4];
  assign bus0.Data_In6 = pix_drv[5];  assign bus1.Data_In6 = pix_drv[5];
  assign bus0.Data_In7 = pix_drv[6];  assign bus1.Data_In7 = pix_drv[6];
  assign bus0.Data_In8 = pix_drv[7];  assign bus1.Data_In8 = pix_drv[7];
  assign bus0.Data_In9 = pix_drv[8];  assign bus1.Data_In9 = pix_drv[8];
  assign bus0.Valid_In = valid_drv;    assign bus1.Valid_In = valid_drv;
  assign bus0.Cfg_Wr   = cfg_wr_drv;   assign bus1.Cfg_Wr   = cfg_wr_drv;
  assign bus0.Cfg_Addr = cfg_addr_drv; assign bus1.Cfg_Addr = cfg_addr_drv;
  assign bus0.Cfg_Data = cfg_data_drv; assign bus1.Cfg_Data = cfg_data_drv;

  conv3x3_mac_relu #(
    .DATA_WIDHT(DW), .WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .IMG_WIDHT(IW),
    .IMG_HEIGHT(IH), .SHIFT(0), .ACC_WIDTH(AW)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  conv3x3_mac_relu #(
    .DATA_WIDHT(DW), .WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .IMG_WIDHT(IW),
    .IMG_HEIGHT(IH), .SHIFT(2), .ACC_WIDTH(AW)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int stamp;
    int d0;
    int d1;
    bit fd;
  } exp_t;

  exp_t exp_q[$];
  int   got0_q[$];
  int   got1_q[$];
  int   w_m[9];
  int   bias_m   = 0;
  int   beat_pos = 0;
  int   res_cnt  = 0;
  int   last0    = 0;
  int   last1    = 0;
  int   seen     = 0;
  int   fd_seen  = 0;
  bit   mon_en   = 1'b0;
  int   zpx[9]   = '{default: 0};

  // Convolution result straight from the arithmetic rules.
  function automatic int model_pix(input int px[9], input int w[9], input int b, input int sh);
    int acc;
    acc = b;
    for (int i = 0; i < 9; i++) acc += px[i] * w[i];
    acc = acc >>> sh;
    if (acc < 0) return 0;
    if (acc > PMAX) return PMAX;
    return acc;
  endfunction

  // One clock of stimulus. The model evaluates the window with the kernel in
  // force before this edge, then applies any config write.
  task automatic step(input bit v, input int px[9], input bit wr, input int addr, input int data);
    exp_t e;
    logic signed [WW-1:0] wv;
    logic signed [BW-1:0] bv;
    @(negedge clk);
    valid_drv = v;
    for (int i = 0; i < 9; i++) pix_drv[i] = DW'(px[i]);
    cfg_wr_drv   = wr;
    cfg_addr_drv = 4'(addr);
    cfg_data_drv = BW'(data);
    if (v) begin
      // Position p in the frame has column (p+2) mod W; columns 0 and 1 straddle rows.
      if (((beat_pos + 2) % IW) >= 2) begin
        res_cnt++;
        e.stamp = cyc + 4;
        e.d0    = model_pix(px, w_m, bias_m, 0);
        e.d1    = model_pix(px, w_m, bias_m, 2);
        e.fd    = (res_cnt == N_RES);
        if (res_cnt == N_RES) res_cnt = 0;
        exp_q.push_back(e);
      end
      beat_pos = (beat_pos + 1) % N_BEATS;
    end
    if (wr) begin
      if (addr < 9) begin
        wv = WW'(data);
        w_m[addr] = int'(wv);
      end else if (addr == 9) begin
        bv = BW'(data);
        bias_m = int'(bv);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, zpx, 1'b0, 0, 0);
  endtask

  task automatic load_kernel(input int w[9], input int b);
    for (int i = 0; i < 9; i++) step(1'b0, zpx, 1'b1, i, w[i]);
    step(1'b0, zpx, 1'b1, 9, b);
  endtask

  // Asynchronous reset at a falling clock edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check({tag, "_rst_valid0"}, int'(bus0.Valid_Out), 0);
    check({tag, "_rst_data0"},  int'(bus0.Data_Out), 0);
    check({tag, "_rst_fd0"},    int'(bus0.Frame_Done), 0);
    check({tag, "_rst_valid1"}, int'(bus1.Valid_Out), 0);
    check({tag, "_rst_data1"},  int'(bus1.Data_Out), 0);
    valid_drv  = 1'b0;
    cfg_wr_drv = 1'b0;
    exp_q.delete();
    got0_q.delete();
    got1_q.delete();
    for (int i = 0; i < 9; i++) w_m[i] = 0;
    bias_m   = 0;
    beat_pos = 0;
    res_cnt  = 0;
    last0    = 0;
    last1    = 0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
  endtask

  // Per-cycle monitor, sampling 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus0.Valid_Out) seen++;
        if (bus0.Frame_Done) fd_seen++;
        if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_valid0", int'(bus0.Valid_Out), 1);
          check("res_valid1", int'(bus1.Valid_Out), 1);
          check("res_data0",  int'(bus0.Data_Out), e.d0);
          check("res_data1",  int'(bus1.Data_Out), e.d1);
          check("res_fd0",    int'(bus0.Frame_Done), int'(e.fd));
          check("res_fd1",    int'(bus1.Frame_Done), int'(e.fd));
          got0_q.push_back(int'(bus0.Data_Out));
          got1_q.push_back(int'(bus1.Data_Out));
          last0 = e.d0;
          last1 = e.d1;
        end else begin
          check("idle_valid0", int'(bus0.Valid_Out), 0);
          check("idle_valid1", int'(bus1.Valid_Out), 0);
          check("idle_fd0",    int'(bus0.Frame_Done), 0);
          check("hold_data0",  int'(bus0.Data_Out), last0);
          check("hold_data1",  int'(bus1.Data_Out), last1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed single-window vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string name;
    int    px[9];
    int    w[9];
    int    b;
    int    exp0;  // SHIFT=0
    int    exp2;  // SHIFT=2
  } vec_t;

  vec_t vecs[8];
  int   frame_px[N_BEATS][9];
  int   rk_w[9];
  int   rk_b;
  int   id_w[9];

  initial begin
    vecs[0] = '{"identity",   '{7,7,7,7,100,7,7,7,7}, '{0,0,0,0,1,0,0,0,0},        0,      100, 25};
    vecs[1] = '{"saturate",   '{default: 255},        '{default: 127},             0,      255, 255};
    vecs[2] = '{"relu_floor", '{default: 255},        '{default: -128},            -32768, 0,   0};
    vecs[3] = '{"bias_shift", '{default: 10},         '{default: 1},               -10,    80,  20};
    vecs[4] = '{"ramp",       '{1,2,3,4,5,6,7,8,9},   '{1,2,3,4,5,6,7,8,9},        0,      255, 71};
    vecs[5] = '{"alternate",  '{default: 50},         '{-1,1,-1,1,-1,1,-1,1,-1},   60,     10,  2};
    vecs[6] = '{"neg_small",  '{default: 1},          '{-3,0,0,0,0,0,0,0,0},       0,      0,   0};
    vecs[7] = '{"bias_only",  '{default: 9},          '{default: 0},               300,    255, 75};
    for (int i = 0; i < 9; i++) id_w[i] = (i == 4) ? 1 : 0;

    do_reset("init");

    for (int v = 0; v < 8; v++) begin
      do_reset(vecs[v].name);
      load_kernel(vecs[v].w, vecs[v].b);
      step(1'b1, vecs[v].px, 1'b0, 0, 0);
      idle(6);
      check({vecs[v].name, "_count"}, got0_q.size(), 1);
      check({vecs[v].name, "_shift0"}, (got0_q.size() > 0) ? got0_q[got0_q.size()-1] : -1, vecs[v].exp0);
      check({vecs[v].name, "_shift2"}, (got1_q.size() > 0) ? got1_q[got1_q.size()-1] : -1, vecs[v].exp2);
    end

    // -------------------------------------------------------------------------
    // Randomized frames: masking, Frame_Done, back-to-back frames
    // -------------------------------------------------------------------------
    for (int i = 0; i < 9; i++) rk_w[i] = int'($urandom_range(0, 4)) - 2;
    rk_b = int'($urandom_range(0, 200)) - 100;
    for (int k = 0; k < N_BEATS; k++)
      for (int i = 0; i < 9; i++) frame_px[k][i] = int'($urandom_range(0, 63));

    do_reset("frames");
    load_kernel(rk_w, rk_b);
    seen = 0;
    fd_seen = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N_BEATS; k++) step(1'b1, frame_px[k], 1'b0, 0, 0);
    idle(6);
    check("b2b_results", seen, 2 * N_RES);
    check("b2b_frame_done", fd_seen, 2);
    check("b2b_drained", exp_q.size(), 0);

    // Same frame with random idle gaps between beats.
    do_reset("gapped");
    load_kernel(rk_w, rk_b);
    seen = 0;
    fd_seen = 0;
    for (int k = 0; k < N_BEATS; k++) begin
      if (k == 3 || $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      step(1'b1, frame_px[k], 1'b0, 0, 0);
    end
    idle(6);
    check("gap_results", seen, N_RES);
    check("gap_frame_done", fd_seen, 1);
    check("gap_drained", exp_q.size(), 0);

    // -------------------------------------------------------------------------
    // Reset in the middle of a frame, then a clean frame
    // -------------------------------------------------------------------------
    do_reset("pre_mid");
    load_kernel(rk_w, rk_b);
    for (int k = 0; k < 5; k++) step(1'b1, frame_px[k], 1'b0, 0, 0);
    do_reset("mid_frame");
    load_kernel(rk_w, rk_b);
    seen = 0;
    fd_seen = 0;
    for (int k = 0; k < N_BEATS; k++) step(1'b1, frame_px[k], 1'b0, 0, 0);
    idle(6);
    check("post_rst_results", seen, N_RES);
    check("post_rst_frame_done", fd_seen, 1);

    // -------------------------------------------------------------------------
    // Config write racing a window: old weight now, new weight next window
    // -------------------------------------------------------------------------
    do_reset("cfg_race");
    load_kernel(id_w, 0);
    begin
      int px[9];
      px = '{default: 3};
      px[4] = 40;
      step(1'b1, px, 1'b1, 4, 2);
      step(1'b1, px, 1'b0, 0, 0);
    end
    idle(6);
    check("race_count", got0_q.size(), 2);
    check("race_old_w", (got0_q.size() > 0) ? got0_q[0] : -1, 40);
    check("race_new_w", (got0_q.size() > 1) ? got0_q[1] : -1, 80);
    check("race_old_w_s2", (got1_q.size() > 0) ? got1_q[0] : -1, 10);
    check("race_new_w_s2", (got1_q.size() > 1) ? got1_q[1] : -1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
